vec_word_serializer: RTL

VEC_WORD_SERIALIZER -- requirements
Module: vec_word_serializer

---
 rtl/fp_accel_pkg.sv | 14 +
 rtl/fp_hold_reg.sv | 25 ++
 rtl/vec_word_serializer.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/fp_accel_pkg.sv
// Shared fingerprint-accelerator definitions: default geometry and the
// serializer FSM encoding.
package fp_accel;

   localparam int VECTOR_WIDTH_DEF = 160;
   localparam int WORD_NUM_DEF     = 6;
   localparam int LEN_WIDTH_DEF    = 3;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } ser_state_e;

endpackage

// File: rtl/fp_hold_reg.sv
// One-entry fingerprint/length holding register; loads on demand, clears on reset.
module fp_hold_reg #(
   parameter int FP_W  = 960,
   parameter int LEN_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [FP_W-1:0]  d_fp,
   input  logic [LEN_W-1:0] d_len,
   output logic [FP_W-1:0]  q_fp,
   output logic [LEN_W-1:0] q_len
);

   always_ff @(posedge clk) begin
      if (rst) begin
         q_fp  <= '0;
         q_len <= '0;
      end else if (load) begin
         q_fp  <= d_fp;
         q_len <= d_len;
      end
   end

endmodule

// File: rtl/vec_word_serializer.sv
// Streams a multi-word fingerprint out one word per cycle, with one active
// entry plus one buffered entry so consecutive fingerprints run without bubbles.
module vec_word_serializer
   import fp_accel::*;
#(
   parameter int VECTOR_WIDTH = VECTOR_WIDTH_DEF,
   parameter int WORD_NUM     = WORD_NUM_DEF,
   parameter int LEN_WIDTH    = LEN_WIDTH_DEF
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [VECTOR_WIDTH*WORD_NUM-1:0] i_Fingerprint,
   input  logic [LEN_WIDTH-1:0]             i_Len,
   input  logic                             i_Valid,
   output logic                             o_Ready,
   output logic [VECTOR_WIDTH-1:0]          o_Vector,
   output logic                             o_Valid,
   output logic                             o_LastWordOfVector,
   output logic                             o_Busy
);

   localparam int FP_W = VECTOR_WIDTH * WORD_NUM;

   ser_state_e               state, state_n;
   logic [LEN_WIDTH-1:0]     idx, idx_n, idx_inc;
   logic                     buf_full, buf_full_n;
   logic [LEN_WIDTH-1:0]     in_len;
   logic                     accept, last_now;

   logic [FP_W-1:0]          act_fp, buf_fp, act_d_fp;
   logic [LEN_WIDTH-1:0]     act_len, buf_len, act_d_len;
   logic                     act_load, act_src_buf, buf_load, buf_clr;

   logic [VECTOR_WIDTH-1:0]  vec_n;
   logic                     vld_n, last_n, busy_n;

   function automatic logic [VECTOR_WIDTH-1:0] word_at(input logic [FP_W-1:0] fp,
                                                       input logic [LEN_WIDTH-1:0] k);
      word_at = '0;
      for (int j = 0; j < WORD_NUM; j++)
         if (k == LEN_WIDTH'(j)) word_at = fp[j*VECTOR_WIDTH +: VECTOR_WIDTH];
   endfunction

   // Lengths beyond the fingerprint size are clamped at the door so the
   // stored length is always a legal word count.
   assign in_len   = (i_Len > LEN_WIDTH'(WORD_NUM)) ? LEN_WIDTH'(WORD_NUM) : i_Len;
   assign o_Ready  = !rst && !buf_full;
   assign accept   = i_Valid && o_Ready;
   assign idx_inc  = idx + 1'b1;
   assign last_now = (state == ST_SEND) && (idx_inc == act_len);

   assign act_d_fp  = act_src_buf ? buf_fp  : i_Fingerprint;
   assign act_d_len = act_src_buf ? buf_len : in_len;

   fp_hold_reg #(.FP_W(FP_W), .LEN_W(LEN_WIDTH)) u_active (
      .clk   (clk),
      .rst   (rst),
      .load  (act_load),
      .d_fp  (act_d_fp),
      .d_len (act_d_len),
      .q_fp  (act_fp),
      .q_len (act_len)
   );

   fp_hold_reg #(.FP_W(FP_W), .LEN_W(LEN_WIDTH)) u_buffer (
      .clk   (clk),
      .rst   (rst),
      .load  (buf_load),
      .d_fp  (i_Fingerprint),
      .d_len (in_len),
      .q_fp  (buf_fp),
      .q_len (buf_len)
   );

   always_comb begin
      state_n     = state;
      idx_n       = idx;
      vec_n       = '0;
      vld_n       = 1'b0;
      last_n      = 1'b0;
      act_load    = 1'b0;
      act_src_buf = 1'b0;
      buf_load    = 1'b0;
      buf_clr     = 1'b0;
      case (state)
         ST_IDLE: begin
            // Zero-length fingerprints are swallowed here without leaving IDLE.
            if (accept && in_len != '0) begin
               act_load = 1'b1;
               state_n  = ST_SEND;
               idx_n    = '0;
               vec_n    = word_at(i_Fingerprint, LEN_WIDTH'(0));
               vld_n    = 1'b1;
               last_n   = (in_len == LEN_WIDTH'(1));
            end
         end
         ST_SEND: begin
            if (!last_now) begin
               idx_n    = idx_inc;
               vec_n    = word_at(act_fp, idx_inc);
               vld_n    = 1'b1;
               last_n   = (LEN_WIDTH'(idx_inc + 1'b1) == act_len);
               buf_load = accept && (in_len != '0);
            end else if (buf_full) begin
               // Promote the buffered entry directly behind the last word.
               act_load    = 1'b1;
               act_src_buf = 1'b1;
               buf_clr     = 1'b1;
               idx_n       = '0;
               vec_n       = word_at(buf_fp, LEN_WIDTH'(0));
               vld_n       = 1'b1;
               last_n      = (buf_len == LEN_WIDTH'(1));
            end else if (accept && in_len != '0) begin
               act_load = 1'b1;
               idx_n    = '0;
               vec_n    = word_at(i_Fingerprint, LEN_WIDTH'(0));
               vld_n    = 1'b1;
               last_n   = (in_len == LEN_WIDTH'(1));
            end else begin
               state_n = ST_IDLE;
               idx_n   = '0;
            end
         end
         default: state_n = ST_IDLE;
      endcase
   end

   assign buf_full_n = buf_load || (buf_full && !buf_clr);
   assign busy_n     = (state_n == ST_SEND) || buf_full_n;

   always_ff @(posedge clk) begin
      if (rst) begin
         state              <= ST_IDLE;
         idx                <= '0;
         buf_full           <= 1'b0;
         o_Vector           <= '0;
         o_Valid            <= 1'b0;
         o_LastWordOfVector <= 1'b0;
         o_Busy             <= 1'b0;
      end else begin
         state              <= state_n;
         idx                <= idx_n;
         buf_full           <= buf_full_n;
         o_Vector           <= vec_n;
         o_Valid            <= vld_n;
         o_LastWordOfVector <= last_n;
         o_Busy             <= busy_n;
      end
   end

endmodule
